sgpr_busy_table_writer: RTL and testbench
=========================================

Name: sgpr_busy_table_writer

Overview:
Owns the scalar-register busy (scoreboard) table that the issue-side busy-table muxes read. It sets busy bits for SGPR destinations when an instruction issues and clears them when the SALU or LSU retires the write. It exports the full registered table plus an occupancy count and sticky protocol-error flags. It sits beside the issue scoreboard, with one write-set port from issue and two clear ports from retire.

Parameters:
NUMBER_SGPR, 512, table depth; must be a power of two.
SGPR_ADDR_LENGTH, 9, address width; equals log2(NUMBER_SGPR).
MAX_NUMBER_WORDS, 4, maximum words per set or clear request.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-low reset.
set_en  input  1  issue marks destination registers busy.
set_addr  input  SGPR_ADDR_LENGTH  first register of the set range.
set_words  input  3  range length, 1..MAX_NUMBER_WORDS.
salu_clr_en  input  1  SALU retire clears a range.
salu_clr_addr  input  SGPR_ADDR_LENGTH  first register of the SALU clear range.
salu_clr_words  input  3  SALU clear length.
lsu_clr_en  input  1  LSU retire clears a range.
lsu_clr_addr  input  SGPR_ADDR_LENGTH  first register of the LSU clear range.
lsu_clr_words  input  3  LSU clear length.
err_clear  input  1  clears both sticky error flags.
busy_table  output  NUMBER_SGPR  registered busy bit per SGPR.
busy_count  output  SGPR_ADDR_LENGTH+1  registered popcount of busy_table.
set_conflict_err  output  1  sticky: a set targeted an already-busy bit.
clr_idle_err  output  1  sticky: a clear targeted a non-busy bit.

Behaviour:
- Reset (rst low, asynchronous): busy_table, busy_count, set_conflict_err and clr_idle_err all go to 0 immediately, even mid-operation. Requests in that cycle are dropped.
- Range expansion: each request covers registers (addr+i) mod NUMBER_SGPR for i = 0..words-1, so ranges wrap from the top of the table to 0. This matches the rotated read view used by the busy-table muxes.
- Length handling: words = 0 is a no-op. words > MAX_NUMBER_WORDS saturates to MAX_NUMBER_WORDS.
- Latency: requests sampled at edge N are visible on busy_table and busy_count after edge N, i.e. one cycle. There is no combinational path from request inputs to outputs.
- Next-state rule: next = (busy_table & ~salu_mask & ~lsu_mask) | set_mask. Clears apply first, then the set, so set wins on overlap. This supports a retire and a re-issue of the same register in the same cycle.
- SALU and LSU clears may overlap each other; an overlapping clear is harmless.
- busy_count is registered alongside the table and always equals popcount(busy_table); width covers the full value NUMBER_SGPR.
- set_conflict_err sets when any set_mask bit is already busy and is not being cleared this cycle.
- clr_idle_err sets when any bit in either clear mask is not busy in the current busy_table.
- Both error flags hold until err_clear or reset.
  - err_clear takes effect on the clock edge.
  - If a new error and err_clear occur in the same cycle, the error wins and the flag stays 1.
- Errors never block the update; the next-state rule is always applied.
- Full table: all bits busy gives busy_count = NUMBER_SGPR, with no overflow. Empty table gives 0.
- There is no handshake: every port is fire-and-forget with single-cycle validity, and the block never stalls.

Test Plan:
1. Reset, then set_en, set_addr=10, set_words=4 -> next cycle busy_table[13:10]=4'hF, busy_count=4, no errors.
2. Wrap: set_addr=510, set_words=4 -> bits 510, 511, 0 and 1 busy; busy_count=4. Then lsu_clr_addr=511, lsu_clr_words=2 -> bits 511 and 0 clear; busy_count=2.
3. Same-cycle clear and set: with bit 20 busy, salu_clr 20/1 and set 20/1 together -> bit 20 stays 1, busy_count unchanged, set_conflict_err=0.
4. Errors: set 30/1 twice -> set_conflict_err=1 after the second edge. Clear 40/1 while bit 40 is idle -> clr_idle_err=1. Pulse err_clear -> both flags 0 next cycle.
5. Dual clear: with bits 50..53 busy, salu clears 50/3 and lsu clears 52/2 in the same cycle -> all four bits clear, busy_count drops by 4, no error.
6. Reset mid-stream: assert rst low between edges with 6 bits busy -> outputs go to 0 immediately without a clock edge. A set issued in the following cycle after release takes effect normally.

Source files
------------

// File: rtl/sgpr_busy_table_writer.sv
// Scalar-register busy table: issue sets destination ranges busy, SALU/LSU retire clears them.
// Exports the registered table, its popcount and sticky protocol-error flags.
module sgpr_busy_table_writer #(
    parameter int unsigned NUMBER_SGPR      = 512,
    parameter int unsigned SGPR_ADDR_LENGTH = 9,
    parameter int unsigned MAX_NUMBER_WORDS = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        set_en,
    input  logic [SGPR_ADDR_LENGTH-1:0] set_addr,
    input  logic [2:0]                  set_words,
    input  logic                        salu_clr_en,
    input  logic [SGPR_ADDR_LENGTH-1:0] salu_clr_addr,
    input  logic [2:0]                  salu_clr_words,
    input  logic                        lsu_clr_en,
    input  logic [SGPR_ADDR_LENGTH-1:0] lsu_clr_addr,
    input  logic [2:0]                  lsu_clr_words,
    input  logic                        err_clear,
    output logic [NUMBER_SGPR-1:0]      busy_table,
    output logic [SGPR_ADDR_LENGTH:0]   busy_count,
    output logic                        set_conflict_err,
    output logic                        clr_idle_err
);

    localparam logic [2:0] MaxWords = 3'(MAX_NUMBER_WORDS);

    logic [NUMBER_SGPR-1:0]      busy_q, busy_d;
    logic [SGPR_ADDR_LENGTH:0]   count_q, count_d;
    logic                        conflict_q, conflict_d;
    logic                        idle_q, idle_d;
    logic [NUMBER_SGPR-1:0]      set_mask, salu_mask, lsu_mask, clr_mask;
    logic                        conflict_now, idle_now;

    // Expands base/length into a bit mask; the address adder wraps modulo the table depth.
    function automatic logic [NUMBER_SGPR-1:0] range_mask(
        input logic                        en,
        input logic [SGPR_ADDR_LENGTH-1:0] base,
        input logic [2:0]                  words
    );
        logic [NUMBER_SGPR-1:0]      m;
        logic [2:0]                  len;
        logic [SGPR_ADDR_LENGTH-1:0] idx;
        m   = '0;
        len = (words > MaxWords) ? MaxWords : words;
        for (int i = 0; i < int'(MAX_NUMBER_WORDS); i++) begin
            idx = base + SGPR_ADDR_LENGTH'(i);
            if (en && (3'(i) < len)) begin
                m[idx] = 1'b1;
            end
        end
        return m;
    endfunction

    always_comb begin
        set_mask  = range_mask(set_en, set_addr, set_words);
        salu_mask = range_mask(salu_clr_en, salu_clr_addr, salu_clr_words);
        lsu_mask  = range_mask(lsu_clr_en, lsu_clr_addr, lsu_clr_words);
        clr_mask  = salu_mask | lsu_mask;
    end

    // Clears first, then set, so a same-cycle retire and re-issue leaves the bit busy.
    always_comb begin
        busy_d       = (busy_q & ~clr_mask) | set_mask;
        conflict_now = |(set_mask & busy_q & ~clr_mask);
        idle_now     = |(clr_mask & ~busy_q);
        conflict_d   = conflict_now | (conflict_q & ~err_clear);
        idle_d       = idle_now | (idle_q & ~err_clear);
    end

    always_comb begin
        count_d = '0;
        for (int i = 0; i < int'(NUMBER_SGPR); i++) begin
            count_d = count_d + (SGPR_ADDR_LENGTH + 1)'(busy_d[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q     <= '0;
            count_q    <= '0;
            conflict_q <= 1'b0;
            idle_q     <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            count_q    <= count_d;
            conflict_q <= conflict_d;
            idle_q     <= idle_d;
        end
    end

    assign busy_table       = busy_q;
    assign busy_count       = count_q;
    assign set_conflict_err = conflict_q;
    assign clr_idle_err     = idle_q;

endmodule

// File: tb/tb_sgpr_busy_table_writer.sv
// Directed bench for sgpr_busy_table_writer with hand-computed expectations.
module tb_sgpr_busy_table_writer;

    logic         clk = 1'b0;
    logic         rst;
    logic         set_en;
    logic [8:0]   set_addr;
    logic [2:0]   set_words;
    logic         salu_clr_en;
    logic [8:0]   salu_clr_addr;
    logic [2:0]   salu_clr_words;
    logic         lsu_clr_en;
    logic [8:0]   lsu_clr_addr;
    logic [2:0]   lsu_clr_words;
    logic         err_clear;
    logic [511:0] busy_table;
    logic [9:0]   busy_count;
    logic         set_conflict_err;
    logic         clr_idle_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sgpr_busy_table_writer #(
        .NUMBER_SGPR      (512),
        .SGPR_ADDR_LENGTH (9),
        .MAX_NUMBER_WORDS (4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .set_en           (set_en),
        .set_addr         (set_addr),
        .set_words        (set_words),
        .salu_clr_en      (salu_clr_en),
        .salu_clr_addr    (salu_clr_addr),
        .salu_clr_words   (salu_clr_words),
        .lsu_clr_en       (lsu_clr_en),
        .lsu_clr_addr     (lsu_clr_addr),
        .lsu_clr_words    (lsu_clr_words),
        .err_clear        (err_clear),
        .busy_table       (busy_table),
        .busy_count       (busy_count),
        .set_conflict_err (set_conflict_err),
        .clr_idle_err     (clr_idle_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        set_en = 0; set_addr = 0; set_words = 0;
        salu_clr_en = 0; salu_clr_addr = 0; salu_clr_words = 0;
        lsu_clr_en = 0; lsu_clr_addr = 0; lsu_clr_words = 0;
        err_clear = 0;
    endtask

    // One request cycle: drive after an edge, let the next edge sample it, return at edge+1.
    task automatic cyc(input logic se, input int sa, input int sw,
                       input logic ce, input int ca, input int cw,
                       input logic le, input int la, input int lw,
                       input logic ec);
        set_en = se; set_addr = 9'(sa); set_words = 3'(sw);
        salu_clr_en = ce; salu_clr_addr = 9'(ca); salu_clr_words = 3'(cw);
        lsu_clr_en = le; lsu_clr_addr = 9'(la); lsu_clr_words = 3'(lw);
        err_clear = ec;
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic set_req(input int a, input int w);
        cyc(1, a, w, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_errs(input string tag, input logic sc, input logic ci);
        check_eq({tag, "_conflict"}, 32'(set_conflict_err), 32'(sc));
        check_eq({tag, "_idle"}, 32'(clr_idle_err), 32'(ci));
    endtask

    initial begin
        idle_inputs();
        rst = 1'b0;
        #12;
        check_eq("rst_count", 32'(busy_count), 0);
        check_eq("rst_table_any", 32'(|busy_table), 0);
        check_errs("rst", 0, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Basic set
        set_req(10, 4);
        check_eq("set_bits", 32'(busy_table[14:9]), 32'h1E);
        check_eq("set_count", 32'(busy_count), 4);
        check_errs("set", 0, 0);

        // Wrap around the top of the table
        set_req(510, 4);
        check_eq("wrap_hi", 32'(busy_table[511:510]), 32'h3);
        check_eq("wrap_lo", 32'(busy_table[2:0]), 32'h3);
        check_eq("wrap_count", 32'(busy_count), 8);
        cyc(0, 0, 0, 0, 0, 0, 1, 511, 2, 0);
        check_eq("wclr_hi", 32'(busy_table[511:510]), 32'h1);
        check_eq("wclr_lo", 32'(busy_table[1:0]), 32'h2);
        check_eq("wclr_count", 32'(busy_count), 6);
        check_errs("wclr", 0, 0);

        // Same-cycle clear and set of one register
        set_req(20, 1);
        check_eq("b20_count", 32'(busy_count), 7);
        cyc(1, 20, 1, 1, 20, 1, 0, 0, 0, 0);
        check_eq("reissue_bit", 32'(busy_table[20]), 1);
        check_eq("reissue_count", 32'(busy_count), 7);
        check_errs("reissue", 0, 0);

        // Sticky errors
        set_req(30, 1);
        check_errs("first30", 0, 0);
        set_req(30, 1);
        check_errs("dup30", 1, 0);
        check_eq("dup30_count", 32'(busy_count), 8);
        cyc(0, 0, 0, 1, 40, 1, 0, 0, 0, 0);
        check_errs("idle40", 1, 1);
        check_eq("idle40_count", 32'(busy_count), 8);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        check_errs("errclr", 0, 0);
        // New error in the same cycle as err_clear wins
        cyc(1, 30, 1, 0, 0, 0, 0, 0, 0, 1);
        check_errs("errwin", 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        check_errs("errclr2", 0, 0);

        // Overlapping SALU and LSU clears
        set_req(50, 4);
        check_eq("b50_count", 32'(busy_count), 12);
        cyc(0, 0, 0, 1, 50, 3, 1, 52, 2, 0);
        check_eq("dual_bits", 32'(busy_table[54:49]), 0);
        check_eq("dual_count", 32'(busy_count), 8);
        check_errs("dual", 0, 0);

        // Length handling: zero is a no-op, oversize saturates
        set_req(60, 0);
        check_eq("w0_bit", 32'(busy_table[60]), 0);
        check_eq("w0_count", 32'(busy_count), 8);
        set_req(70, 7);
        check_eq("w7_bits", 32'(busy_table[74:69]), 32'h1E);
        check_eq("w7_count", 32'(busy_count), 12);
        check_errs("len", 0, 0);

        // Asynchronous reset between edges
        cyc(0, 0, 0, 0, 0, 0, 1, 80, 1, 0);
        check_errs("pre_rst", 0, 1);
        #2 rst = 1'b0;
        #1;
        check_eq("arst_count", 32'(busy_count), 0);
        check_eq("arst_table_any", 32'(|busy_table), 0);
        check_errs("arst", 0, 0);
        #2 rst = 1'b1;
        @(posedge clk); #1;
        set_req(100, 2);
        check_eq("post_bits", 32'(busy_table[102:99]), 32'h6);
        check_eq("post_count", 32'(busy_count), 2);

        // Full table and back to empty
        rst = 1'b0; #1; rst = 1'b1;
        for (int a = 0; a < 512; a += 4) set_req(a, 4);
        check_eq("full_count", 32'(busy_count), 512);
        check_eq("full_table_all", 32'(&busy_table), 1);
        check_errs("full", 0, 0);
        set_req(0, 1);
        check_errs("full_dup", 1, 0);
        check_eq("full_dup_count", 32'(busy_count), 512);
        for (int a = 0; a < 512; a += 4) cyc(0, 0, 0, 1, a, 4, 0, 0, 0, 0);
        check_eq("empty_count", 32'(busy_count), 0);
        check_eq("empty_table_any", 32'(|busy_table), 0);
        check_errs("empty", 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
